// File: rtl/fu_busy_scheduler_int_pkg.sv
// Shared latency constants, FSM encodings and parameter legality check for the
// integer mul/div occupancy tracker.
package fu_busy_scheduler_int_pkg;

   localparam int ISSUE_WIDTH_INT = 4;
   localparam int MUL_LAT_INT     = 3;
   localparam int DIV_LAT_INT     = 8;

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_DIV_RUN = 1'b1;

   // The divider must finish strictly after any multiply issued in the same
   // cycle, so the two writebacks on one port can never land together.
   function automatic bit lat_legal(input int mul_lat, input int div_lat);
      return (mul_lat >= 1) && (mul_lat <= 8) &&
             (div_lat >= 2) && (div_lat <= 64) &&
             (div_lat > mul_lat);
   endfunction

endpackage

// File: rtl/fu_busy_scheduler_int_port.sv
// One issue port: divider FSM + down-counter and multiplier token shift register.
// All outputs are flops computed from next-state; flush clears everything on the next edge.
module fu_busy_scheduler_int_port
   import fu_busy_scheduler_int_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_INT,
   parameter int DIV_LAT = DIV_LAT_INT
) (
   input  logic clock,
   input  logic reset,
   input  logic issue_valid,
   input  logic issue_is_mul,
   input  logic issue_is_div,
   input  logic flush,
   output logic ex_busy,
   output logic mul_wb_valid,
   output logic div_wb_valid
);

   localparam int CW = $clog2(DIV_LAT + 1);

   logic [0:0]         state, state_nxt;
   logic [CW-1:0]      cnt, cnt_nxt;
   logic [MUL_LAT-1:0] mul_sr, mul_sr_nxt;
   logic               div_wb_nxt;
   logic               mul_busy_nxt;
   logic               take, take_div, take_mul;

   // A conflicting mul+div uop is handled as a divide.
   assign take     = issue_valid && !flush && !ex_busy;
   assign take_div = take && issue_is_div;
   assign take_mul = take && issue_is_mul && !issue_is_div;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      div_wb_nxt = 1'b0;
      if (flush) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = '0;
      end else if (state == ST_DIV_RUN) begin
         if (cnt == '0) begin
            state_nxt = ST_IDLE;
         end else begin
            cnt_nxt = cnt - CW'(1);
         end
         div_wb_nxt = (cnt == CW'(1));
      end else if (take_div) begin
         state_nxt = ST_DIV_RUN;
         cnt_nxt   = CW'(DIV_LAT - 1);
      end
   end

   // Top bit of the shift register is the writeback flop itself.
   assign mul_sr_nxt = flush ? '0 : ((mul_sr << 1) | MUL_LAT'(take_mul));

   if (MUL_LAT >= 2) begin : g_mul_busy
      assign mul_busy_nxt = mul_sr_nxt[MUL_LAT-2];
   end else begin : g_no_mul_busy
      assign mul_busy_nxt = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         mul_sr       <= '0;
         ex_busy      <= 1'b0;
         div_wb_valid <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         mul_sr       <= mul_sr_nxt;
         ex_busy      <= (state_nxt == ST_DIV_RUN) | mul_busy_nxt;
         div_wb_valid <= div_wb_nxt;
      end
   end

   assign mul_wb_valid = mul_sr[MUL_LAT-1];

   assert property (@(posedge clock) disable iff (reset)
                    !(issue_valid && !flush && ex_busy))
      else $warning("fu_busy port: issue to a busy port ignored");

   assert property (@(posedge clock) disable iff (reset)
                    !(issue_valid && issue_is_mul && issue_is_div))
      else $warning("fu_busy port: mul and div both set, handled as div");

endmodule

// File: rtl/fu_busy_scheduler_int.sv
// Per-port mul/div occupancy tracker feeding ex_busy to issue_queue_int and
// writeback-slot pulses to the mul/div result muxes; ports are independent.
module fu_busy_scheduler_int
   import fu_busy_scheduler_int_pkg::*;
#(
   parameter int ISSUE_WIDTH = ISSUE_WIDTH_INT,
   parameter int MUL_LAT     = MUL_LAT_INT,
   parameter int DIV_LAT     = DIV_LAT_INT
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [ISSUE_WIDTH-1:0] issue_valid,
   input  logic [ISSUE_WIDTH-1:0] issue_is_mul,
   input  logic [ISSUE_WIDTH-1:0] issue_is_div,
   input  logic                   flush,
   output logic [ISSUE_WIDTH-1:0] ex_busy,
   output logic [ISSUE_WIDTH-1:0] mul_wb_valid,
   output logic [ISSUE_WIDTH-1:0] div_wb_valid
);

   if (!lat_legal(MUL_LAT, DIV_LAT) || (ISSUE_WIDTH < 1)) begin : g_bad_params
      $error("fu_busy_scheduler_int: illegal ISSUE_WIDTH/MUL_LAT/DIV_LAT combination");
   end

   for (genvar p = 0; p < ISSUE_WIDTH; p++) begin : g_port
      fu_busy_scheduler_int_port #(
         .MUL_LAT (MUL_LAT),
         .DIV_LAT (DIV_LAT)
      ) u_port (
         .clock        (clock),
         .reset        (reset),
         .issue_valid  (issue_valid[p]),
         .issue_is_mul (issue_is_mul[p]),
         .issue_is_div (issue_is_div[p]),
         .flush        (flush),
         .ex_busy      (ex_busy[p]),
         .mul_wb_valid (mul_wb_valid[p]),
         .div_wb_valid (div_wb_valid[p])
      );
   end

endmodule

// File: doc/fu_busy_scheduler_int.md
Name: fu_busy_scheduler_int

Overview:
- Tracks occupancy of the multi-cycle functional units behind each integer issue port: iterative divider and pipelined multiplier.
- Drives the ex_busy vector consumed by issue_queue_int, so the queue never selects a uop for a port that is occupied or would collide at writeback.
- Emits per-port writeback-slot pulses for the mul/div result muxes.
- Sits between the issue_queue_int select outputs and the integer execute stage.

Parameters:
ISSUE_WIDTH, `ISSUE_WIDTH_INT, number of integer issue ports tracked.
MUL_LAT, 3, multiplier latency in cycles, issue to writeback; legal range 1..8.
DIV_LAT, 8, divider latency in cycles, issue to writeback; non-pipelined; legal range 2..64.

Ports:
clock  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-high; clears all state.
issue_valid  input  [ISSUE_WIDTH]  uop issued on port p this cycle.
issue_is_mul  input  [ISSUE_WIDTH]  issued uop targets the multiplier (fu_code.fu_mul).
issue_is_div  input  [ISSUE_WIDTH]  issued uop targets the divider (fu_code.fu_div).
flush  input  1  pipeline squash (mispredict/exception); kills all in-flight mul/div.
ex_busy  output  [ISSUE_WIDTH]  registered; port p must not be issued to this cycle.
mul_wb_valid  output  [ISSUE_WIDTH]  registered; multiplier result on port p writes back this cycle.
div_wb_valid  output  [ISSUE_WIDTH]  registered; divider result on port p writes back this cycle.

Behaviour:
- Per port: one 2-state FSM (IDLE, DIV_RUN), one down-counter of width $clog2(DIV_LAT+1), one MUL_LAT-bit shift register of in-flight multiplies.
- Reset (async, any time, including mid-divide): FSM=IDLE, counter=0, shift register=0; ex_busy, mul_wb_valid and div_wb_valid all 0 on the same edge as reset assertion.
- An issue is sampled at the rising edge closing cycle t when issue_valid[p]=1 and flush=0.
- is_mul and is_div both set on one port: protocol error. The sim assertion fires; the uop is treated as div.
- Divide issued in cycle t:
  - FSM goes to DIV_RUN and counter loads DIV_LAT-1.
  - ex_busy[p]=1 in cycles t+1 .. t+DIV_LAT.
  - div_wb_valid[p]=1 only in cycle t+DIV_LAT.
  - FSM returns to IDLE, and ex_busy[p]=0 from cycle t+DIV_LAT+1 unless another reason holds it.
- Multiply issued in cycle t:
  - Token enters the shift register; mul_wb_valid[p]=1 in cycle t+MUL_LAT. For MUL_LAT=1, token is written directly to the output register.
  - If MUL_LAT>=2, ex_busy[p]=1 in cycle t+MUL_LAT-1. This blocks a 1-cycle ALU uop from colliding with the mul writeback.
  - Back-to-back multiplies are legal; each gets its own token.
- ex_busy[p] = DIV_RUN, OR the mul token that is one stage before the output register. Computed from next-state so the output is a flop, not combinational.
- Issue while ex_busy[p]=1 is a protocol violation: sim assertion fires, the issue is ignored, state is unchanged.
- Divide issued while mul tokens are in flight on the same port: allowed. Writeback cycles differ by construction because DIV_LAT > MUL_LAT is required; elaboration fails otherwise.
- Flush:
  - On the next edge: all FSMs to IDLE, counters to 0, shift registers to 0.
  - ex_busy, mul_wb_valid and div_wb_valid are 0 in the following cycle.
  - An issue in the same cycle as flush is dropped.
- Ports are fully independent; no cross-port arbitration.

Decomposition:
- Shared package (micro_op.svh / int_fu_pkg): MUL_LAT_INT and DIV_LAT_INT constants, plus the parameter legality checks.
- One sub-module, fu_busy_port: a single port's FSM, counter and shift register. The top instantiates ISSUE_WIDTH copies in a generate loop and adds the shared flush fan-out.

Test Plan:
1. Reset, then divide on port 0 issued in cycle 5 -> ex_busy[0]=1 in cycles 6..13; div_wb_valid[0] pulses in cycle 13 only; ex_busy[0]=0 in cycle 14; ports 1.. remain 0.
2. Multiplies on port 1 in cycles 4 and 5 (MUL_LAT=3) -> ex_busy[1]=1 in cycles 6 and 7; mul_wb_valid[1]=1 in cycles 7 and 8.
3. Divide on port 0 in cycle 3, flush in cycle 6 -> ex_busy[0]=0 from cycle 7; no div_wb_valid pulse in cycles 7..20.
4. Issue plus flush in the same cycle on all ports -> outputs stay 0 for 10 cycles.
5. Reset asserted mid-divide in cycle 8 (div issued in cycle 3) -> outputs 0 immediately, without waiting for an edge; a new divide in cycle 12 behaves as in scenario 1.
6. Issue to a busy port (issue_valid[0]=1 in cycle 7 during the divide) -> assertion fires; div_wb_valid[0] still pulses in cycle 11 only.
